// File: rtl/mux_scan_ctrl_pkg.sv
// Shared types and sizing for the mux scan sequencer.
package mux_scan_pkg;

  localparam int NUM_CH         = 4;
  localparam int SEL_W_FIX      = $clog2(NUM_CH);
  localparam int SETTLE_CYC_MAX = 15;
  localparam int CNT_W          = $clog2(SETTLE_CYC_MAX + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2
  } scan_state_e;

endpackage

// File: rtl/mux_scan_ctrl_if.sv
// Handshake and mux-facing signals of the scan sequencer.
interface mux_scan_ctrl_if;
  import mux_scan_pkg::*;

  logic                  start;
  logic                  cont;
  logic                  mux_out;
  logic [SEL_W_FIX-1:0]  sel;
  logic                  busy;
  logic                  done;
  logic [NUM_CH-1:0]     data_out;

  modport master (
    output start, cont, mux_out,
    input  sel, busy, done, data_out
  );

  modport slave (
    input  start, cont, mux_out,
    output sel, busy, done, data_out
  );

endinterface

// File: rtl/mux_scan_ctrl_settle_cnt.sv
// Loadable settle down-counter; holds at zero and flags it.
module mux_scan_settle_cnt
  import mux_scan_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             dec_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;

  // Load has priority over decrement; never wraps below zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mux_scan_ctrl.sv
// Mux scan sequencer: steps sel through 0..3, settles, samples mux_out
// and assembles the samples into one word.
//
//   state  | meaning
//   IDLE   | waiting for start, sel parked at 0
//   SETTLE | sel just changed, counting settle cycles
//   SAMPLE | one cycle; mux_out captured at its closing edge
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int unsigned SETTLE_CYC = 1,
  parameter int unsigned SEL_W      = 2
) (
  input logic            clk,
  input logic            rst,
  mux_scan_ctrl_if.slave bus
);

  if (SEL_W != 2) begin : g_bad_sel_w
    $error("mux_scan_ctrl: SEL_W must be 2");
  end
  if (SETTLE_CYC > SETTLE_CYC_MAX) begin : g_bad_settle
    $error("mux_scan_ctrl: SETTLE_CYC must be 0..15");
  end

  // With no settle time every channel goes straight to SAMPLE.
  localparam scan_state_e      FIRST_ST = (SETTLE_CYC == 0) ? SAMPLE : SETTLE;
  localparam logic [CNT_W-1:0] LOAD_VAL =
    (SETTLE_CYC == 0) ? '0 : CNT_W'(SETTLE_CYC - 1);
  localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(NUM_CH - 1);

  scan_state_e             state_q, state_d;
  logic [SEL_W-1:0]        sel_q, sel_d;
  logic [NUM_CH-2:0]       shadow_q, shadow_d;
  logic [NUM_CH-1:0]       data_q, data_d;
  logic                    done_q, done_d;
  logic                    busy_q, busy_d;
  logic                    cnt_load, cnt_dec, cnt_zero;

  mux_scan_settle_cnt u_settle_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (cnt_load),
    .dec_i      (cnt_dec),
    .load_val_i (LOAD_VAL),
    .zero_o     (cnt_zero)
  );

  // State and datapath registers; reset discards any partial word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      shadow_q <= '0;
      data_q   <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      shadow_q <= shadow_d;
      data_q   <= data_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    shadow_d = shadow_q;
    data_d   = data_q;
    done_d   = 1'b0;
    busy_d   = busy_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;

    case (state_q)
      IDLE: begin
        sel_d  = '0;
        busy_d = 1'b0;
        // The done cycle still belongs to the finished scan, so a start
        // seen there is not taken.
        if (bus.start && !done_q) begin
          busy_d   = 1'b1;
          state_d  = FIRST_ST;
          cnt_load = 1'b1;
        end
      end

      SETTLE: begin
        if (cnt_zero) begin
          state_d = SAMPLE;
        end else begin
          cnt_dec = 1'b1;
        end
      end

      SAMPLE: begin
        if (sel_q == LAST_CH) begin
          data_d = {bus.mux_out, shadow_q};
          done_d = 1'b1;
          sel_d  = '0;
          if (bus.cont) begin
            state_d  = FIRST_ST;
            cnt_load = 1'b1;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end else begin
          case (sel_q)
            2'd0:    shadow_d[0] = bus.mux_out;
            2'd1:    shadow_d[1] = bus.mux_out;
            2'd2:    shadow_d[2] = bus.mux_out;
            default: ;
          endcase
          sel_d    = sel_q + SEL_W'(1);
          state_d  = FIRST_ST;
          cnt_load = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.sel      = sel_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.data_out = data_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl: four builds (settle 0, 1, 3, 15),
// each with a behavioural 4:1 mux driven from a bench-held input word.
module tb_mux_scan_ctrl;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [3:0]      start_r;
  logic [3:0]      cont_r;
  logic [3:0][3:0] in_vec;
  logic [3:0][1:0] sel_w;
  logic [3:0]      busy_w;
  logic [3:0]      done_w;
  logic [3:0][3:0] data_w;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int unsigned S = (g == 0) ? 0 : (g == 1) ? 1 : (g == 2) ? 3 : 15;
    mux_scan_ctrl_if bus ();
    mux_scan_ctrl #(.SETTLE_CYC(S), .SEL_W(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );
    assign bus.start   = start_r[g];
    assign bus.cont    = cont_r[g];
    assign bus.mux_out = in_vec[g][bus.sel];
    assign sel_w[g]    = bus.sel;
    assign busy_w[g]   = bus.busy;
    assign done_w[g]   = bus.done;
    assign data_w[g]   = bus.data_out;
  end

  function automatic int s_of(int k);
    return (k == 0) ? 0 : (k == 1) ? 1 : (k == 2) ? 3 : 15;
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One start pulse, then the scan is followed cycle by cycle. Cycle j is
  // the cycle beginning j edges after the accepting edge.
  task automatic scan(int k, logic [3:0] v, bit seq);
    int s;
    int len;
    s   = s_of(k);
    len = 4 * (s + 1);
    in_vec[k]  = v;
    start_r[k] = 1'b1;
    tick();
    start_r[k] = 1'b0;
    for (int j = 0; j < len; j++) begin
      if (seq) begin
        chk("sel_seq", 32'(sel_w[k]), 32'(j / (s + 1)));
        chk("busy_scan", 32'(busy_w[k]), 32'd1);
        chk("done_early", 32'(done_w[k]), 32'd0);
      end
      tick();
    end
    chk("done", 32'(done_w[k]), 32'd1);
    chk("data", 32'(data_w[k]), 32'(v));
    chk("sel_wrap", 32'(sel_w[k]), 32'd0);
    tick();
    chk("busy_after", 32'(busy_w[k]), 32'd0);
    chk("done_pulse", 32'(done_w[k]), 32'd0);
  endtask

  initial begin
    int n_done;
    logic [3:0] v;

    start_r = '0;
    cont_r  = '0;
    in_vec  = '0;

    #2;
    for (int k = 0; k < 4; k++) begin
      chk("rst_sel", 32'(sel_w[k]), 32'd0);
      chk("rst_busy", 32'(busy_w[k]), 32'd0);
      chk("rst_done", 32'(done_w[k]), 32'd0);
      chk("rst_data", 32'(data_w[k]), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Basic scans with full sequence checks.
    scan(1, 4'b1010, 1'b1);
    scan(0, 4'b0101, 1'b1);
    scan(2, 4'b1110, 1'b1);

    // Second start while busy is dropped.
    in_vec[1]  = 4'b1100;
    start_r[1] = 1'b1;
    tick();
    start_r[1] = 1'b0;
    n_done = 0;
    for (int j = 0; j < 30; j++) begin
      if (j == 3) start_r[1] = 1'b1;
      if (j == 4) start_r[1] = 1'b0;
      if (done_w[1]) n_done++;
      tick();
    end
    chk("busy_start_one_done", 32'(n_done), 32'd1);
    chk("busy_start_idle", 32'(busy_w[1]), 32'd0);
    chk("busy_start_data", 32'(data_w[1]), 32'hC);

    // Start held through done: ignored in the done cycle, taken next cycle.
    in_vec[1]  = 4'b0110;
    start_r[1] = 1'b1;
    tick();
    for (int j = 0; j < 8; j++) tick();
    chk("hold_done", 32'(done_w[1]), 32'd1);
    tick();
    chk("hold_ignored_in_done", 32'(busy_w[1]), 32'd0);
    tick();
    chk("hold_accepted", 32'(busy_w[1]), 32'd1);
    start_r[1] = 1'b0;
    for (int j = 0; j < 8; j++) tick();
    chk("hold_second_done", 32'(done_w[1]), 32'd1);
    chk("hold_second_data", 32'(data_w[1]), 32'h6);
    tick();

    // Continuous mode: input changes before channel 0 of scan two is
    // sampled; cont cleared mid-scan ends after that scan.
    cont_r[1]  = 1'b1;
    in_vec[1]  = 4'b1010;
    start_r[1] = 1'b1;
    tick();
    start_r[1] = 1'b0;
    for (int j = 0; j < 16; j++) begin
      chk("cont_busy", 32'(busy_w[1]), 32'd1);
      if (j == 8) begin
        chk("cont_done1", 32'(done_w[1]), 32'd1);
        chk("cont_data1", 32'(data_w[1]), 32'hA);
        in_vec[1] = 4'b0011;
      end else begin
        chk("cont_no_done", 32'(done_w[1]), 32'd0);
      end
      if (j == 11) cont_r[1] = 1'b0;
      tick();
    end
    chk("cont_done2", 32'(done_w[1]), 32'd1);
    chk("cont_data2", 32'(data_w[1]), 32'h3);
    tick();
    chk("cont_stop_busy", 32'(busy_w[1]), 32'd0);
    chk("cont_stop_done", 32'(done_w[1]), 32'd0);

    // Asynchronous reset in the middle of a scan.
    in_vec[1]  = 4'b1001;
    start_r[1] = 1'b1;
    tick();
    start_r[1] = 1'b0;
    tick();
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_sel", 32'(sel_w[1]), 32'd0);
    chk("mid_rst_busy", 32'(busy_w[1]), 32'd0);
    chk("mid_rst_done", 32'(done_w[1]), 32'd0);
    chk("mid_rst_data", 32'(data_w[1]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    scan(1, 4'b1001, 1'b1);
    scan(3, 4'b0111, 1'b1);

    // Mixed builds, random words held for each scan.
    for (int i = 0; i < 50; i++) begin
      v = 4'($urandom_range(0, 15));
      scan(i % 4, v, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_scan_ctrl.md
Name: mux_scan_ctrl

Overview:
- Sequencer that sits directly upstream and downstream of the 4:1 mux (mux4to1_assign).
- Drives the mux `sel` through channels 0..3, waits a programmable settle time per channel, samples the mux `out`, and assembles the four samples into a 4-bit word.
- Start/done handshake; optional continuous re-scan.
- Used to read back a 4-bit bus serially through the shared mux.

Parameters:
- SETTLE_CYC, 1, settle cycles per channel after `sel` changes and before sampling; legal 0..15.
- SEL_W, 2, select width. Fixed at 2 (4 channels). Any other value is rejected by an elaboration-time check.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  scan request; sampled only in IDLE
- cont  input  1  continuous mode; sampled at scan completion
- mux_out  input  1  output of the 4:1 mux for the current `sel`
- sel  output  2  mux select, registered
- busy  output  1  high from the cycle after `start` is accepted until the scan ends (see Behaviour)
- done  output  1  one-cycle pulse; `data_out` is valid from this cycle
- data_out  output  4  assembled word; bit i is the sample taken with sel=i

Behaviour:
- Reset (async, rst=1): state=IDLE, sel=0, busy=0, done=0, data_out=0, internal shadow=0, settle counter=0.
  - A reset during a scan discards the partial word; `data_out` returns to 0.
- States: IDLE, SETTLE, SAMPLE.
- IDLE:
  - sel=0, busy=0.
  - start=1 at an edge -> SETTLE, sel=0, counter=SETTLE_CYC-1.
  - If SETTLE_CYC=0, go straight to SAMPLE.
- SETTLE:
  - busy=1; counter decrements each cycle.
  - At counter==0 -> SAMPLE on the next edge. SETTLE therefore lasts exactly SETTLE_CYC cycles.
- SAMPLE (one cycle):
  - At the closing edge, capture mux_out into shadow[sel].
  - If sel<3: sel <= sel+1, then -> SETTLE, reloading the counter (or stay in SAMPLE if SETTLE_CYC=0).
  - If sel==3 (wrap):
    - data_out <= {mux_out, shadow[2:0]}, done <= 1, sel <= 0.
    - cont=1: -> SETTLE (or SAMPLE) for channel 0 immediately. busy stays 1 and there is no IDLE cycle.
    - cont=0: -> IDLE, busy <= 0.
- Latency: done is high in the cycle beginning at edge E0 + 4*(SETTLE_CYC+1), where E0 is the edge that accepted `start`.
  - SETTLE_CYC=1: 8 cycles.
  - SETTLE_CYC=0: 4 cycles.
- `sel` changes only on a SAMPLE->next transition, so it holds stable for SETTLE_CYC+1 cycles per channel.
- start while busy: ignored; it is not queued.
- start=1 in the same cycle as done, with cont=0: ignored, because the block is not yet in IDLE. It is accepted the following cycle if still high.
- `data_out` holds its value between scans and updates only at done.
- `done` is a single-cycle pulse, also in continuous mode (one pulse per completed word).
- Clearing `cont` mid-scan takes effect at the next completion only.

Decomposition:
- Shared package mux_scan_pkg:
  - state enum (IDLE, SETTLE, SAMPLE)
  - localparam NUM_CH=4
  - localparam CNT_W = $clog2(SETTLE_CYC_MAX+1) with SETTLE_CYC_MAX=15
- Optional sub-module mux_scan_settle_cnt: loadable down-counter with a zero flag.
- The top level instantiates the FSM and the counter. The mux itself stays external, so the bench connects it alongside mux4to1_assign.

Test Plan:
- Reset mid-scan: start, then assert rst at cycle 3 -> sel=0, busy=0, done=0, data_out=0 asynchronously; the next start produces a full, correct word.
- SETTLE_CYC=1, mux in=4'b1010, start pulse -> sel sequence 0,0,1,1,2,2,3,3; done at cycle 8 after acceptance; data_out=4'b1010; busy=0 the cycle after done.
- SETTLE_CYC=0, in=4'b0101 -> sel changes every cycle; done 4 cycles after start; data_out=4'b0101.
- Start while busy: second start pulse at cycle 3 of a scan -> ignored; exactly one done; no extra scan.
- Continuous: cont=1, in=1010, then change in to 0011 during the second scan before channel 0 is sampled -> done pulses 8 cycles apart; data_out=1010 then 0011; busy never drops.
- Independent model check: randomize in, hold it stable per scan, run 50 scans with random SETTLE_CYC builds (0, 1, 3, 15) -> data_out==in at every done.
